// File: rtl/sha256_compress.sv
// SHA-256 compression stage: one round per accepted schedule word, then a hash-state fold.
// Define SHA_CHAIN_EN to add chain_i, which lets a start continue from the previous digest.
module sha256_compress #(
  parameter int ROUNDS = 64
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         start_i,
`ifdef SHA_CHAIN_EN
  input  logic         chain_i,
`endif
  input  logic         w_valid_i,
  input  logic [31:0]  w_i,
  output logic         w_ready_o,
  output logic         busy_o,
  output logic         done_o,
  output logic [255:0] digest_o
);

  typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_t;

  localparam logic [255:0] IV = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  localparam logic [5:0]   T_LAST = 6'(ROUNDS - 1);

  localparam logic [31:0] K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    rotr = (x >> n) | (x << (32 - n));
  endfunction

  state_t       r_state, w_state_next;
  logic [5:0]   r_t;
  logic [31:0]  r_wv [8];      // working variables, index 0 = a .. 7 = h
  logic [31:0]  r_hs [8];      // hash state the block started from
  logic [255:0] r_digest;

  logic [255:0] w_init;
  logic [31:0]  w_init_word [8];
  logic [255:0] w_sum;
  logic [31:0]  w_s0, w_s1, w_ch, w_maj, w_t1, w_t2;
  logic         w_beat;

`ifdef SHA_CHAIN_EN
  assign w_init = chain_i ? r_digest : IV;
`else
  assign w_init = IV;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_word
      assign w_init_word[gi]         = w_init[255-32*gi -: 32];
      assign w_sum[255-32*gi -: 32]  = r_hs[gi] + r_wv[gi];
    end
  endgenerate

  assign w_s0  = rotr(r_wv[0], 2) ^ rotr(r_wv[0], 13) ^ rotr(r_wv[0], 22);
  assign w_s1  = rotr(r_wv[4], 6) ^ rotr(r_wv[4], 11) ^ rotr(r_wv[4], 25);
  assign w_ch  = (r_wv[4] & r_wv[5]) ^ (~r_wv[4] & r_wv[6]);
  assign w_maj = (r_wv[0] & r_wv[1]) ^ (r_wv[0] & r_wv[2]) ^ (r_wv[1] & r_wv[2]);
  assign w_t1  = r_wv[7] + w_s1 + w_ch + K[r_t] + w_i;
  assign w_t2  = w_s0 + w_maj;
  assign w_beat = w_valid_i && w_ready_o;
  assign digest_o = r_digest;

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_ready_o    = 1'b0;
    busy_o       = 1'b1;
    done_o       = 1'b0;
    case (r_state)
      IDLE: begin
        busy_o = 1'b0;
        if (start_i) w_state_next = ROUND;
      end
      ROUND: begin
        w_ready_o = 1'b1;
        if (w_valid_i && r_t == T_LAST) w_state_next = FINAL;
      end
      FINAL: w_state_next = DONE;
      DONE: begin
        done_o       = 1'b1;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // t parks at the last index after the final beat and is cleared in FINAL.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_t      <= '0;
      r_digest <= IV;
      for (int i = 0; i < 8; i++) begin
        r_wv[i] <= '0;
        r_hs[i] <= IV[255-32*i -: 32];
      end
    end else begin
      case (r_state)
        IDLE: if (start_i) begin
          r_t <= '0;
          for (int i = 0; i < 8; i++) begin
            r_wv[i] <= w_init_word[i];
            r_hs[i] <= w_init_word[i];
          end
        end
        ROUND: if (w_beat) begin
          r_wv[7] <= r_wv[6];
          r_wv[6] <= r_wv[5];
          r_wv[5] <= r_wv[4];
          r_wv[4] <= r_wv[3] + w_t1;
          r_wv[3] <= r_wv[2];
          r_wv[2] <= r_wv[1];
          r_wv[1] <= r_wv[0];
          r_wv[0] <= w_t1 + w_t2;
          if (r_t != T_LAST) r_t <= r_t + 6'd1;
        end
        FINAL: begin
          r_digest <= w_sum;
          r_t      <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_compress.sv
// Scoreboard bench for sha256_compress: known-answer digests, gaps, mid-block reset, ignored starts.
// Build with SHA_CHAIN_EN defined to also exercise the two-block chained message.
`timescale 1ns/1ps
module tb_sha256_compress;
  localparam int ROUNDS = 64;
  localparam logic [255:0] IV      = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  localparam logic [255:0] D_ABC   = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] D_EMPTY = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
  localparam logic [255:0] D_TWO   = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

  logic         clk_i = 1'b0;
  logic         rst_i, start_i, w_valid_i;
  logic [31:0]  w_i;
  logic         w_ready_o, busy_o, done_o;
  logic [255:0] digest_o;
`ifdef SHA_CHAIN_EN
  logic         chain_i = 1'b0;
`endif

  int checks = 0;
  int failures = 0;
  logic [255:0] exp_q [$];
  logic [31:0]  blk [16];
  logic [31:0]  sched [64];

  always #5 clk_i = ~clk_i;

  sha256_compress #(.ROUNDS(ROUNDS)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .start_i   (start_i),
`ifdef SHA_CHAIN_EN
    .chain_i   (chain_i),
`endif
    .w_valid_i (w_valid_i),
    .w_i       (w_i),
    .w_ready_o (w_ready_o),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .digest_o  (digest_o)
  );

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    rr = (x >> n) | (x << (32 - n));
  endfunction

  // Software message expansion of blk[] into sched[].
  task automatic expand();
    for (int t = 0; t < 64; t++) begin
      if (t < 16) sched[t] = blk[t];
      else sched[t] = (rr(sched[t-2], 17) ^ rr(sched[t-2], 19) ^ (sched[t-2] >> 10)) + sched[t-7]
                    + (rr(sched[t-15], 7) ^ rr(sched[t-15], 18) ^ (sched[t-15] >> 3)) + sched[t-16];
    end
  endtask

  // Runs one block from IDLE (called at a negedge); optionally aborts with rst_i after abort_after beats.
  task automatic run_block(input bit chk, input logic [255:0] exp, input bit gaps, input int abort_after,
                           input bit pulse_start, input bit hold_chk, input logic [255:0] hold_exp);
    int beats, guard, lat, ready_errs;
    bit v;
    logic [255:0] e;
    if (chk) exp_q.push_back(exp);
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    checks++;
    if (busy_o !== 1'b1 || w_ready_o !== 1'b1) begin
      $display("FAIL start_to_round busy=%0b w_ready=%0b required 1/1", busy_o, w_ready_o);
      failures++;
    end
    if (hold_chk) begin
      checks++;
      if (digest_o !== hold_exp) begin
        $display("FAIL digest_hold got=%h required=%h", digest_o, hold_exp);
        failures++;
      end
    end
    beats = 0; guard = 0; ready_errs = 0;
    while (beats < ROUNDS && guard < 1000) begin
      if (abort_after > 0 && beats == abort_after) break;
      if (w_ready_o !== 1'b1) ready_errs++;
      v = gaps ? ($urandom_range(0, 1) == 1) : 1'b1;
      w_valid_i = v;
      w_i = v ? sched[beats] : $urandom;
      start_i = pulse_start && (beats == 10 || beats == 40);
      @(negedge clk_i);
      if (v) beats++;
      guard++;
    end
    w_valid_i = 1'b0;
    start_i = 1'b0;
    checks++;
    if (ready_errs != 0 || guard >= 1000) begin
      $display("FAIL round_ready ready_errs=%0d cycles=%0d required 0 errs", ready_errs, guard);
      failures++;
    end
    if (abort_after > 0) begin
      rst_i = 1'b1;
      @(negedge clk_i);
      rst_i = 1'b0;
      exp_q.delete();
      checks++;
      if (busy_o !== 1'b0 || w_ready_o !== 1'b0 || done_o !== 1'b0) begin
        $display("FAIL abort_idle busy=%0b w_ready=%0b done=%0b required 0/0/0", busy_o, w_ready_o, done_o);
        failures++;
      end
      checks++;
      if (digest_o !== IV) begin
        $display("FAIL abort_digest got=%h required=%h", digest_o, IV);
        failures++;
      end
      $display("block aborted after %0d beats", beats);
      return;
    end
    checks++;
    if (w_ready_o !== 1'b0) begin
      $display("FAIL ready_drop w_ready=%0b required 0", w_ready_o);
      failures++;
    end
    lat = 1;
    while (done_o !== 1'b1 && lat < 8) begin
      @(negedge clk_i);
      lat++;
    end
    checks++;
    if (lat != 2) begin
      $display("FAIL done_latency cycles=%0d required 2", lat);
      failures++;
    end
    if (done_o === 1'b1) begin
      if (chk) begin
        checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL scoreboard_empty got=%h required an expected entry", digest_o);
          failures++;
        end else begin
          e = exp_q.pop_front();
          if (digest_o !== e) begin
            $display("FAIL digest got=%h required=%h", digest_o, e);
            failures++;
          end
        end
      end
      $display("block done digest=%h beats=%0d cycles=%0d", digest_o, beats, guard);
      start_i = 1'b1;
      @(negedge clk_i);
      start_i = 1'b0;
      checks++;
      if (done_o !== 1'b0 || busy_o !== 1'b0) begin
        $display("FAIL done_pulse_or_start_in_done done=%0b busy=%0b required 0/0", done_o, busy_o);
        failures++;
      end
    end
  endtask

  task automatic load_abc();
    for (int i = 0; i < 16; i++) blk[i] = 32'h0;
    blk[0] = 32'h61626380;
    blk[15] = 32'h00000018;
    expand();
  endtask

  task automatic test_reset();
    rst_i = 1'b1; start_i = 1'b0; w_valid_i = 1'b0; w_i = '0;
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      w_valid_i = 1'b1;
      w_i = $urandom;
      @(negedge clk_i);
      checks++;
      if (digest_o !== IV || w_ready_o !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b0) begin
        $display("FAIL reset_idle digest=%h rdy=%0b busy=%0b done=%0b required IV/0/0/0",
                 digest_o, w_ready_o, busy_o, done_o);
        failures++;
      end
    end
    w_valid_i = 1'b0;
    $display("reset idle checked");
  endtask

  task automatic test_abc();
    load_abc();
    run_block(1'b1, D_ABC, 1'b0, 0, 1'b0, 1'b0, '0);
  endtask

  task automatic test_empty_gaps();
    for (int i = 0; i < 16; i++) blk[i] = 32'h0;
    blk[0] = 32'h80000000;
    expand();
    run_block(1'b1, D_EMPTY, 1'b1, 0, 1'b0, 1'b1, D_ABC);
  endtask

  task automatic test_reset_mid();
    load_abc();
    run_block(1'b1, D_ABC, 1'b0, 30, 1'b0, 1'b1, D_EMPTY);
  endtask

  task automatic test_start_ignored();
    load_abc();
    run_block(1'b1, D_ABC, 1'b0, 0, 1'b1, 1'b1, IV);
  endtask

`ifdef SHA_CHAIN_EN
  task automatic test_chain();
    blk = '{32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667, 32'h65666768, 32'h66676869,
            32'h6768696a, 32'h68696a6b, 32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
            32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    expand();
    chain_i = 1'b0;
    run_block(1'b0, '0, 1'b0, 0, 1'b0, 1'b1, D_ABC);
    for (int i = 0; i < 16; i++) blk[i] = 32'h0;
    blk[15] = 32'h000001c0;
    expand();
    repeat (3) @(negedge clk_i);
    chain_i = 1'b1;
    run_block(1'b1, D_TWO, 1'b1, 0, 1'b0, 1'b0, '0);
    chain_i = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_abc();
    test_empty_gaps();
    test_reset_mid();
    test_start_ignored();
`ifdef SHA_CHAIN_EN
    test_chain();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
